// File: rtl/cla_slice_sequencer.sv
// Multi-cycle wide adder: streams operands one data_width slice per cycle through
// a single CLA slice, rippling the carry through a register between slices.

module carry_gen_adder #(
  parameter int unsigned data_width = 4
) (
  input  logic [data_width-1:0] a,
  input  logic [data_width-1:0] b,
  input  logic                  cin,
  output logic [data_width-1:0] sum,
  output logic                  cout
);

  logic [data_width-1:0] g;
  logic [data_width-1:0] p;
  logic [data_width:0]   carry;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is expanded from cin and the lower generate/propagate terms.
  always_comb begin
    logic acc;
    carry    = '0;
    acc      = 1'b0;
    carry[0] = cin;
    for (int i = 0; i < int'(data_width); i++) begin
      acc = cin;
      for (int j = 0; j <= i; j++) begin
        acc = g[j] | (p[j] & acc);
      end
      carry[i+1] = acc;
    end
  end

  assign sum  = p ^ carry[data_width-1:0];
  assign cout = carry[data_width];

endmodule

module cla_slice_sequencer #(
  parameter int unsigned data_width = 4,
  parameter int unsigned num_slices = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [data_width*num_slices-1:0] in_a,
  input  logic [data_width*num_slices-1:0] in_b,
  input  logic                             in_cin,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [data_width*num_slices-1:0] out_sum,
  output logic                             out_cout,
  output logic                             out_ovf
);

  localparam int unsigned TW   = data_width * num_slices;
  localparam int unsigned IW   = (num_slices > 1) ? $clog2(num_slices) : 1;
  localparam int unsigned LAST = num_slices - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   a_q, a_d;
  logic [TW-1:0]   b_q, b_d;
  logic [TW-1:0]   sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            ovf_q, ovf_d;
  logic            valid_q, valid_d;

  logic [data_width-1:0] slice_a;
  logic [data_width-1:0] slice_b;
  logic [data_width-1:0] slice_sum;
  logic                  slice_cout;

  // Slice mux feeding the single CLA instance.
  assign slice_a = a_q[32'(idx_q) * data_width +: data_width];
  assign slice_b = b_q[32'(idx_q) * data_width +: data_width];

  carry_gen_adder #(.data_width(data_width)) u_cla (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[32'(idx_q) * data_width +: data_width] = slice_sum;
        carry_d = slice_cout;
        idx_d   = idx_q + IW'(1);
        if (idx_q == IW'(LAST)) begin
          // Final slice: its sum MSB is the result MSB used for overflow.
          ovf_d   = (a_q[TW-1] == b_q[TW-1]) && (slice_sum[data_width-1] != a_q[TW-1]);
          idx_d   = '0;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = carry_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Self-checking bench: default 16-bit sequencer plus a single-slice instance,
// directed and random operands checked against integer-arithmetic expectations.

module tb_cla_slice_sequencer;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, out_ovf;
  logic [15:0] in_a, in_b, out_sum;

  logic        v1_in, r1_in, cin1, v1_out, r1_out, cout1, ovf1;
  logic [3:0]  a1, b1, sum1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cla_slice_sequencer #(.data_width(4), .num_slices(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  cla_slice_sequencer #(.data_width(4), .num_slices(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(v1_in), .in_ready(r1_in),
    .in_a(a1), .in_b(b1), .in_cin(cin1),
    .out_valid(v1_out), .out_ready(r1_out),
    .out_sum(sum1), .out_cout(cout1), .out_ovf(ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned sum for result/carry, signed integer range for overflow.
  task automatic model16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         output logic [15:0] s, output logic co, output logic ov);
    int unsigned u;
    int sa, sb, t;
    u  = 32'(a) + 32'(b) + 32'(cin);
    s  = u[15:0];
    co = u[16];
    sa = int'($signed(a));
    sb = int'($signed(b));
    t  = sa + sb + int'(cin);
    ov = (t > 32767) || (t < -32768);
  endtask

  // Called at a negedge with the DUT idle.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input int hold, input bit noise);
    logic [15:0] es;
    logic        ec, eo;
    int          lat;
    model16(a, b, cin, es, ec, eo);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    if (noise) begin
      in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (!out_valid) chk("in_ready_run", 32'(in_ready), 32'd0);
    end
    chk("latency", 32'(lat), 32'd4);
    chk("sum", 32'(out_sum), 32'(es));
    chk("cout", 32'(out_cout), 32'(ec));
    chk("ovf", 32'(out_ovf), 32'(eo));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'(out_sum), 32'(es));
      chk("hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("no_extra", 32'(out_valid), 32'd0);
  endtask

  task automatic run1(input logic [3:0] a, input logic [3:0] b, input logic cin);
    int unsigned u;
    int          lat;
    u = 32'(a) + 32'(b) + 32'(cin);
    chk("ns1_ready", 32'(r1_in), 32'd1);
    a1 = a; b1 = b; cin1 = cin; v1_in = 1'b1; r1_out = 1'b1;
    @(posedge clk); #1;
    v1_in = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!v1_out && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    chk("ns1_latency", 32'(lat), 32'd1);
    chk("ns1_sum", 32'(sum1), 32'(u[3:0]));
    chk("ns1_cout", 32'(cout1), 32'(u[4]));
    @(posedge clk); @(negedge clk);
    chk("ns1_drop", 32'(v1_out), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
    v1_in = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; r1_out = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(out_sum), 32'd0);
    chk("rst_cout", 32'(out_cout), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h00FF, 16'h0000, 1'b1, 0, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0);
    run_op(16'hA5A5, 16'h5A5A, 1'b1, 5, 1'b1);

    // Reset during the second RUN cycle.
    in_a = 16'h1234; in_b = 16'h4321; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(out_sum), 32'd0);
    chk("mid_rst_cout", 32'(out_cout), 32'd0);
    chk("mid_rst_ovf", 32'(out_ovf), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); @(negedge clk);
      chk("mid_rst_quiet", 32'(out_valid), 32'd0);
    end
    run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0);

    for (int n = 0; n < 16; n++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)));
    end

    run1(4'b1010, 4'b0101, 1'b0);
    run1(4'b1111, 4'b0001, 1'b0);
    for (int n = 0; n < 6; n++) begin
      run1(4'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cla_slice_sequencer.md
# cla_slice_sequencer

Multi-cycle wide adder that sits directly upstream of the `carry_gen_adder` slice and drives it. It accepts wide operands over a valid/ready handshake and feeds them into one `data_width`-bit CLA slice per cycle, LSB slice first. It chains each slice's `cout` into the next slice's `cin` through a register, assembles the full sum, and presents it downstream over a second valid/ready handshake. This lets one small CLA instance serve operands of `data_width*num_slices` bits.

## Interface
- `data_width`, default 4: width of one CLA slice; passed to the `carry_gen_adder` instance.
- `num_slices`, default 4: number of slices per operand (≥1); total width `TW = data_width*num_slices` (16 by default).
- `clk` input, 1 bit: single clock; all state updates on rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `in_valid` input, 1 bit: operand set valid.
- `in_ready` output, 1 bit: block can accept operands.
- `in_a` input, TW bits: operand A.
- `in_b` input, TW bits: operand B.
- `in_cin` input, 1 bit: carry into the LSB slice.
- `out_valid` output, 1 bit: result valid.
- `out_ready` input, 1 bit: downstream accepts result.
- `out_sum` output, TW bits: `in_a + in_b + in_cin` mod 2^TW.
- `out_cout` output, 1 bit: carry out of the MSB slice.
- `out_ovf` output, 1 bit: two's-complement overflow.

## Operation
- One internal `carry_gen_adder` instance with port order (a, b, cin, sum, cout). Its inputs are the selected operand slices and the carry register.
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`: capture `in_a`, `in_b` into operand registers; set carry register ← `in_cin`; set slice index ← 0; go to RUN.
- **RUN**
  - `in_ready`=0.
  - Each cycle the adder sees `a_reg[idx*data_width +: data_width]`, `b_reg[...]`, and the carry register.
  - At the edge: write the adder `sum` into `sum_reg[idx*data_width +: data_width]`; set carry register ← `cout`; increment idx.
  - When idx == num_slices-1 at the edge, go to DONE.
- **DONE**
  - `out_valid`=1; `out_sum`=`sum_reg`; `out_cout`=carry register.
  - `out_ovf` = (`a_reg[TW-1]` == `b_reg[TW-1]`) && (`sum_reg[TW-1]` != `a_reg[TW-1]`).
  - On `out_valid && out_ready`: go to IDLE.
- Outputs are held stable while `out_valid`=1 and `out_ready`=0.
- `in_valid` is ignored outside IDLE; operands are not queued.
- Slice index counter width: `$clog2(num_slices)`, minimum 1 bit.
- With `num_slices`=1, RUN lasts exactly one cycle.
- **Reset values:** state=IDLE, `in_ready`=1 (combinational from IDLE), `out_valid`=0, `out_sum`=0, `out_cout`=0, `out_ovf`=0, carry register=0, idx=0.
- **Reset mid-operation** (RUN or DONE): the result is discarded, the block returns to IDLE on the next edge, and no `out_valid` pulse is produced.

## Timing
- An input handshake at edge T puts the block in RUN for edges T+1 … T+num_slices.
- `out_valid` rises after edge T+num_slices. Latency is `num_slices` cycles from acceptance to `out_valid` visible: 4 cycles by default.
- An output handshake at edge D puts the block in IDLE after D, so `in_ready`=1 from cycle D+1.
- Minimum spacing between accepts is num_slices+2 cycles; there is no same-cycle output/input overlap.
- The carry ripples between slices through the register only, one slice per cycle. The critical path is one CLA slice plus the slice mux.

## Test plan
- 0x1234 + 0x4321, cin=0, out_ready=1 -> `out_sum`=0x5555, `out_cout`=0, `out_ovf`=0, `out_valid` asserted exactly 4 cycles after accept and for 1 cycle.
- 0xFFFF + 0x0001, cin=0 -> `out_sum`=0x0000, `out_cout`=1, `out_ovf`=0; the carry propagates through all 4 slices. Also 0x7FFF + 0x0001 -> 0x8000, `out_cout`=0, `out_ovf`=1.
- 0x00FF + 0x0000, cin=1 -> 0x0100, `out_cout`=0. Then 0x8000 + 0x8000, cin=0 -> 0x0000, `out_cout`=1, `out_ovf`=1.
- Backpressure: out_ready=0 for 5 cycles in DONE -> `out_valid` and `out_sum` stay constant and `in_ready`=0. A new `in_valid` pulse during RUN/DONE is ignored and produces no extra result.
- Reset asserted in the 2nd RUN cycle -> next cycle all outputs 0 and `in_ready`=1. A subsequent 0x0001 + 0x0001 -> 0x0002 correctly.
- `num_slices`=1, `data_width`=4: 1010 + 0101, cin=0 -> 1111, `out_cout`=0, 1-cycle latency. Then 1111 + 0001 -> 0000, `out_cout`=1.
